// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader;
// also usable by processor-level benches.
package program_loader_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    FILL,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/program_loader_timeout.sv
// Idle-cycle counter for the loader: clears on every accepted byte, counts
// while enabled, and saturates at TIMEOUT where it reports expiry.
module loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a framed byte stream (A5, N, N bytes, XOR
// checksum), pads the tail with HALT and holds the core until a load succeeds.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int IDX_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  n_reg;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [7:0]        acc;
  logic              accept;
  logic              timed;
  logic              tmo_exp;
  logic              n_bad;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [7:0]        data_p1;

  assign timed    = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign in_ready = (state == IDLE) || (timed && !tmo_exp);
  assign accept   = in_valid && in_ready;
  assign idx_inc  = idx + IDX_W'(1);
  assign n_bad    = (in_data == 8'd0) || (in_data > 8'(DEPTH));

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (timed),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && in_data == FRAME_HDR) state_nxt = COUNT;
      COUNT: begin
        if (tmo_exp)     state_nxt = ERROR;
        else if (accept) state_nxt = n_bad ? ERROR : DATA;
      end
      DATA: begin
        if (tmo_exp) begin
          state_nxt = ERROR;
        end else if (accept && idx_inc == n_reg) begin
          state_nxt = (n_reg < IDX_W'(DEPTH)) ? FILL : CHECK;
        end
      end
      FILL:  if (idx == IDX_W'(DEPTH - 1)) state_nxt = CHECK;
      CHECK: begin
        if (tmo_exp)     state_nxt = ERROR;
        else if (accept) state_nxt = (in_data == acc) ? DONE : ERROR;
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write-port stage: one registered write per cycle, data or HALT padding
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1        <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      n_reg        <= '0;
      idx          <= '0;
      acc          <= '0;
      cpu_hold     <= 1'b0;
      words_loaded <= '0;
    end else begin
      we_p1 <= 1'b0;
      case (state)
        IDLE: if (accept && in_data == FRAME_HDR) cpu_hold <= 1'b1;
        COUNT: begin
          if (accept && !n_bad) begin
            n_reg <= in_data[IDX_W-1:0];
            acc   <= in_data;
            idx   <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            we_p1   <= 1'b1;
            addr_p1 <= idx[ADDR_W-1:0];
            data_p1 <= in_data;
            acc     <= acc ^ in_data;
            idx     <= idx_inc;
          end
        end
        FILL: begin
          we_p1   <= 1'b1;
          addr_p1 <= idx[ADDR_W-1:0];
          data_p1 <= OP_HALT;
          idx     <= idx_inc;
        end
        CHECK: if (accept && in_data == acc) words_loaded <= n_reg;
        DONE:  cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_we     = we_p1;
  assign mem_addr   = addr_p1;
  assign mem_data   = data_p1;
  assign load_done  = (state == DONE);
  assign cpu_rst    = (state == DONE);
  assign load_error = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader with a frame-level memory model.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              cpu_hold;
  logic              cpu_rst;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .cpu_hold    (cpu_hold),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image as seen through the write port, plus pulse counters
  logic [7:0] tb_mem [DEPTH];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, rst_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (load_done)  done_cnt <= done_cnt + 1;
    if (load_error) err_cnt  <= err_cnt + 1;
    if (cpu_rst)    rst_cnt  <= rst_cnt + 1;
  end

  // Reference model state
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] fr_data [$];
  int         exp_wr, exp_done, exp_err;
  logic       exp_hold = 1'b0;
  logic [4:0] exp_words = '0;
  int         wr0, done0, err0, rst0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept_in_time", 32'(t < 100), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic snap();
    wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt; rst0 = rst_cnt;
  endtask

  // Frame-level model: what memory image and outcome a frame must produce
  task automatic model(input logic [7:0] n, input int nsend, input bit send_chk,
                       input logic [7:0] ck);
    logic [7:0] x;
    exp_wr = 0; exp_done = 0; exp_err = 0;
    exp_hold = 1'b1;
    if (n == 0 || n > DEPTH) begin
      exp_err = 1;
      return;
    end
    x = n;
    for (int i = 0; i < nsend; i++) begin
      exp_mem[i] = fr_data[i];
      x = x ^ fr_data[i];
      exp_wr++;
    end
    if (nsend == int'(n)) begin
      for (int a = int'(n); a < DEPTH; a++) begin
        exp_mem[a] = OP_HALT;
        exp_wr++;
      end
    end
    if (nsend != int'(n) || !send_chk || ck != x) begin
      exp_err = 1;
    end else begin
      exp_done  = 1;
      exp_hold  = 1'b0;
      exp_words = n[4:0];
    end
  endtask

  function automatic logic [7:0] frame_xor(input logic [7:0] n);
    logic [7:0] x;
    x = n;
    foreach (fr_data[i]) x = x ^ fr_data[i];
    return x;
  endfunction

  task automatic frame(input logic [7:0] n, input int nsend, input bit send_chk,
                       input logic [7:0] ck, input int long_gap_idx);
    send(FRAME_HDR);
    gap($urandom_range(0, 2));
    send(n);
    if (n != 0 && n <= DEPTH) begin
      for (int i = 0; i < nsend; i++) begin
        if (i == long_gap_idx) gap(TIMEOUT - 20);
        else gap($urandom_range(0, 3));
        send(fr_data[i]);
      end
      if (send_chk) begin
        gap($urandom_range(0, 3));
        send(ck);
      end
    end
  endtask

  task automatic check_frame(input string tag);
    gap(20);
    #1;
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    chk({tag, "_done"}, 32'(done_cnt - done0), 32'(exp_done));
    chk({tag, "_cpu_rst"}, 32'(rst_cnt - rst0), 32'(exp_done));
    chk({tag, "_error"}, 32'(err_cnt - err0), 32'(exp_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    for (int a = 0; a < DEPTH; a++)
      chk($sformatf("%s_mem%0d", tag, a), 32'(tb_mem[a]), 32'(exp_mem[a]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(mem_data), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_error"}, 32'(load_error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    logic [7:0] n, ck;
    int found;
    for (int a = 0; a < DEPTH; a++) begin
      tb_mem[a]  = 8'h00;
      exp_mem[a] = 8'h00;
    end

    // Reset values
    gap(3);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal load
    fr_data = '{8'h18, 8'h28, 8'hFF};
    snap();
    frame(8'h03, 3, 1'b1, 8'hCC, -1);
    model(8'h03, 3, 1'b1, 8'hCC);
    check_frame("normal");

    // Bad checksum
    fr_data = '{8'h11, 8'h22};
    snap();
    frame(8'h02, 2, 1'b1, 8'h00, -1);
    model(8'h02, 2, 1'b1, 8'h00);
    check_frame("badsum");

    // Count errors
    fr_data = {};
    snap();
    frame(8'h00, 0, 1'b0, 8'h00, -1);
    model(8'h00, 0, 1'b0, 8'h00);
    check_frame("n_zero");
    snap();
    frame(8'h11, 0, 1'b0, 8'h00, -1);
    model(8'h11, 0, 1'b0, 8'h00);
    check_frame("n_17");

    // Full depth with random gaps and one long gap just under the timeout
    fr_data = {};
    for (int i = 0; i < DEPTH; i++) fr_data.push_back(8'($urandom));
    ck = frame_xor(8'h10);
    snap();
    frame(8'h10, DEPTH, 1'b1, ck, 7);
    model(8'h10, DEPTH, 1'b1, ck);
    check_frame("full");

    // Noise before header, then a frame stalled mid-data until timeout
    snap();
    send(8'h00);
    send(8'h7E);
    #1;
    chk("noise_hold", 32'(cpu_hold), 32'd0);
    chk("noise_writes", 32'(wr_cnt - wr0), 32'd0);
    fr_data = '{8'h11, 8'h22};
    frame(8'h02, 1, 1'b0, 8'h00, -1);
    gap(TIMEOUT - 5);
    #1;
    chk("timeout_not_early", 32'(err_cnt - err0), 32'd0);
    found = 0;
    for (int t = 0; t < 30 && found == 0; t++) begin
      @(negedge clk);
      #1;
      if (err_cnt != err0) found = 1;
    end
    chk("timeout_fired", 32'(found), 32'd1);
    model(8'h02, 1, 1'b0, 8'h00);
    check_frame("timeout");

    // Good frame following the timeout
    fr_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ck = frame_xor(8'h05);
    snap();
    frame(8'h05, 5, 1'b1, ck, -1);
    model(8'h05, 5, 1'b1, ck);
    check_frame("after_tmo");

    // Randomized frames, some with a corrupted checksum
    for (int k = 0; k < 6; k++) begin
      n = 8'($urandom_range(1, DEPTH));
      fr_data = {};
      for (int i = 0; i < int'(n); i++) fr_data.push_back(8'($urandom));
      ck = frame_xor(n);
      if (k % 3 == 2) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      snap();
      frame(n, int'(n), 1'b1, ck, -1);
      model(n, int'(n), 1'b1, ck);
      check_frame($sformatf("rand%0d", k));
    end

    // Reset after 2 of 4 data bytes
    fr_data = '{8'h31, 8'h32, 8'h33, 8'h34};
    snap();
    send(FRAME_HDR);
    send(8'h04);
    send(fr_data[0]);
    send(fr_data[1]);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_mem[0] = 8'h31;
    exp_mem[1] = 8'h32;
    exp_wr = 2; exp_done = 0; exp_err = 0;
    exp_hold = 1'b0; exp_words = '0;
    check_frame("midrst_img");

    // Clean frame after the reset
    fr_data = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
    ck = frame_xor(8'h04);
    snap();
    frame(8'h04, 4, 1'b1, ck, -1);
    model(8'h04, 4, 1'b1, ck);
    check_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
